net2axis_stream_arbiter: RTL and testbench
==========================================

Name: net2axis_stream_arbiter

Overview:
- Packet-level round-robin arbiter that merges C_NUM_SRC AXI-Stream sources into one AXI-Stream master.
- Sits upstream of the net2axis capture slave, so several net2axis masters can share one capture sink and one output file.
- A grant is held for a whole packet (through TLAST), so packets are never interleaved.

Parameters:
- C_TDATA_WIDTH, 32, data width of every stream in bits; multiple of 8.
- C_NUM_SRC, 2, number of source streams; legal range 2..8.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  allows new grants; does not abort a packet in flight.
- S_AXIS_TVALID  in  C_NUM_SRC  per-source valid.
- S_AXIS_TDATA  in  C_NUM_SRC*C_TDATA_WIDTH  per-source data; source i occupies slice i.
- S_AXIS_TKEEP  in  C_NUM_SRC*C_TDATA_WIDTH/8  per-source keep.
- S_AXIS_TLAST  in  C_NUM_SRC  per-source last.
- S_AXIS_TREADY  out  C_NUM_SRC  per-source ready.
- M_AXIS_TVALID  out  1  merged valid.
- M_AXIS_TDATA  out  C_TDATA_WIDTH  merged data.
- M_AXIS_TKEEP  out  C_TDATA_WIDTH/8  merged keep.
- M_AXIS_TLAST  out  1  merged last.
- M_AXIS_TREADY  in  1  sink ready.
- GRANT  out  $clog2(C_NUM_SRC)  index of the granted source; valid while BUSY.
- BUSY  out  1  high while a packet is being forwarded.
- PKT_CNT  out  C_NUM_SRC*16  per-source completed-packet counters (see Optional Feature).

Behaviour:
- Clock and reset: one clock, ACLK. ARESETN is asynchronous and active-low.
- Reset values: state IDLE, GRANT 0, BUSY 0, last-served pointer C_NUM_SRC-1 (so source 0 wins first), all S_AXIS_TREADY 0, M_AXIS_TVALID 0, M_AXIS_TDATA/TKEEP/TLAST 0, PKT_CNT 0.
- IDLE state:
  - Outputs are quiescent: all TREADY 0, M_AXIS_* 0.
  - If ENABLE=1 and any S_AXIS_TVALID is set, pick the first valid source searching from last+1 upward with wrap-around.
  - Register the pick into GRANT, set BUSY=1, and go to XFER on the next edge.
- XFER state: combinational pass-through of the granted source only.
  - M_AXIS_TVALID/TDATA/TKEEP/TLAST = granted source's signals.
  - S_AXIS_TREADY[GRANT] = M_AXIS_TREADY; all other TREADY bits are 0.
  - On a beat with M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST: last := GRANT, BUSY := 0, return to IDLE.
- Latency and throughput:
  - 1 cycle from a valid appearing in IDLE to the first forwarded beat.
  - 1 mandatory IDLE cycle between packets, which makes throughput N beats per N+1 cycles.
  - No further pipeline; the data path is zero-latency in XFER.
- Boundary conditions:
  - Single-beat packet (TVALID and TLAST on the first beat): one XFER cycle, then back to IDLE.
  - Granted source drops TVALID mid-packet: stay in XFER holding GRANT, with M_AXIS_TVALID=0.
  - ENABLE falls during XFER: the packet completes; no new grant until ENABLE returns high.
  - Simultaneous requests: strict rotation. With sources 0 and 1 both always valid, grants alternate 0,1,0,1.
  - Non-granted sources see TREADY=0 for their entire wait (AXI rule: they hold their data).
  - Reset asserted mid-packet: outputs clear immediately (asynchronously); the partial packet is dropped from the arbiter's view.
  - GRANT is stable for the whole XFER state.

Optional Feature:
- Macro: NET2AXIS_ARB_STATS_EN.
- Defined: one 16-bit counter per source, incremented on each TLAST handshake from that source, saturating at 16'hFFFF (no wrap). Counters clear only on reset. Counter i is driven on PKT_CNT[16*i +: 16].
- Undefined: the counters are not built and PKT_CNT is tied to 0. The port list is identical in both builds.

Decomposition:
- Package net2axis_pkg holds:
  - state encoding (IDLE=0, XFER=1);
  - COUNTER_WIDTH=16;
  - the MD_MARKER constant, shared with the other net2axis blocks.
- Sub-module net2axis_rr_pick: combinational round-robin selector.
  - Inputs: request vector and last-served pointer.
  - Outputs: grant index and found flag.
  - Reusable by the future multi-sink scheduler.

Test Plan:
- Reset, then source 0 sends a 3-beat packet (TDATA 0x11,0x22,0x33; TLAST on beat 3) with M_AXIS_TREADY=1 → first M beat 1 cycle after TVALID; output beats identical; BUSY high for 3 cycles; then IDLE; GRANT=0.
- Sources 0 and 1 continuously valid with 2-beat packets → grants alternate 0,1,0,1 and no beats are interleaved; with the macro, PKT_CNT after 4 packets is 2/2.
- M_AXIS_TREADY toggles 1,0,1,0 during a 4-beat packet → each beat held stable while TREADY=0; S_AXIS_TREADY[GRANT] mirrors M_AXIS_TREADY; packet completes in 8 cycles.
- ENABLE=0 with source 1 valid → no grant and all TREADY stay 0; ENABLE=1 → grant to 1 on the next edge. Drop ENABLE mid-packet → packet still completes.
- ARESETN pulled low on beat 2 of a 4-beat packet → M_AXIS_TVALID, BUSY and TREADY go to 0 before the next edge; after release the next grant goes to source 0.
- Single-beat packet (TLAST on first beat) → one XFER cycle; the next request is granted after one IDLE cycle.

Source files
------------

// File: rtl/net2axis_pkg.sv
// Shared definitions for the net2axis blocks: arbiter state encoding,
// statistics counter width and the metadata marker constant.
package net2axis_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int COUNTER_WIDTH = 16;

    localparam logic [31:0] MD_MARKER = 32'h4E32_414D;

    // Saturating increment: a full counter holds its value.
    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] value);
        logic [COUNTER_WIDTH-1:0] result;
        if (value == {COUNTER_WIDTH{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/net2axis_rr_pick.sv
// Combinational round-robin selector: first set request bit searching
// upward from last+1 with wrap-around.
module net2axis_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          found
);

    int idx_s;

    // Scan the N candidates in rotation order, keep the first hit.
    always_comb begin
        grant = {IW{1'b0}};
        found = 1'b0;
        idx_s = 0;
        for (int k = 1; k <= N; k++) begin
            idx_s = (int'(last) + k) % N;
            if (!found && req[IW'(idx_s)]) begin
                grant = IW'(idx_s);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/net2axis_stream_arbiter.sv
// Packet-level round-robin merge of C_NUM_SRC AXI-Stream sources into one master.
// Optional per-source packet counters: define NET2AXIS_ARB_STATS_EN.
module net2axis_stream_arbiter
    import net2axis_pkg::*;
#(
    parameter int C_TDATA_WIDTH = 32,
    parameter int C_NUM_SRC     = 2
) (
    input  logic                                 ACLK,
    input  logic                                 ARESETN,
    input  logic                                 ENABLE,
    input  logic [C_NUM_SRC-1:0]                 S_AXIS_TVALID,
    input  logic [C_NUM_SRC*C_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_NUM_SRC*C_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic [C_NUM_SRC-1:0]                 S_AXIS_TLAST,
    output logic [C_NUM_SRC-1:0]                 S_AXIS_TREADY,
    output logic                                 M_AXIS_TVALID,
    output logic [C_TDATA_WIDTH-1:0]             M_AXIS_TDATA,
    output logic [C_TDATA_WIDTH/8-1:0]           M_AXIS_TKEEP,
    output logic                                 M_AXIS_TLAST,
    input  logic                                 M_AXIS_TREADY,
    output logic [$clog2(C_NUM_SRC)-1:0]         GRANT,
    output logic                                 BUSY,
    output logic [C_NUM_SRC*16-1:0]              PKT_CNT
);

    localparam int KW = C_TDATA_WIDTH / 8;
    localparam int GW = $clog2(C_NUM_SRC);

    arb_state_e      state_r, state_next_s;
    logic [GW-1:0]   grant_r, grant_next_s;
    logic [GW-1:0]   last_r, last_next_s;
    logic [GW-1:0]   pick_s;
    logic            busy_r, busy_next_s;
    logic            found_s;
    logic            beat_last_s;

    logic [C_TDATA_WIDTH-1:0] src_data_s [C_NUM_SRC];
    logic [KW-1:0]            src_keep_s [C_NUM_SRC];

    for (genvar i = 0; i < C_NUM_SRC; i++) begin : g_unpack
        assign src_data_s[i] = S_AXIS_TDATA[i*C_TDATA_WIDTH +: C_TDATA_WIDTH];
        assign src_keep_s[i] = S_AXIS_TKEEP[i*KW +: KW];
    end

    net2axis_rr_pick #(
        .N  (C_NUM_SRC),
        .IW (GW)
    ) u_rr_pick (
        .req   (S_AXIS_TVALID),
        .last  (last_r),
        .grant (pick_s),
        .found (found_s)
    );

    // Zero-latency pass-through of the granted source; quiescent when idle.
    always_comb begin
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = {C_TDATA_WIDTH{1'b0}};
        M_AXIS_TKEEP  = {KW{1'b0}};
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = {C_NUM_SRC{1'b0}};
        if (state_r == XFER) begin
            M_AXIS_TVALID          = S_AXIS_TVALID[grant_r];
            M_AXIS_TDATA           = src_data_s[grant_r];
            M_AXIS_TKEEP           = src_keep_s[grant_r];
            M_AXIS_TLAST           = S_AXIS_TLAST[grant_r];
            S_AXIS_TREADY[grant_r] = M_AXIS_TREADY;
        end else begin
            M_AXIS_TVALID = 1'b0;
        end
    end

    assign beat_last_s = (state_r == XFER) && M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;

    // Next-state: grant on a request in IDLE, release after the TLAST handshake.
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        last_next_s  = last_r;
        busy_next_s  = busy_r;
        case (state_r)
            IDLE: begin
                if (ENABLE && found_s) begin
                    state_next_s = XFER;
                    grant_next_s = pick_s;
                    busy_next_s  = 1'b1;
                end else begin
                    busy_next_s  = 1'b0;
                end
            end
            XFER: begin
                if (beat_last_s) begin
                    state_next_s = IDLE;
                    last_next_s  = grant_r;
                    busy_next_s  = 1'b0;
                end else begin
                    busy_next_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // Arbiter state registers; the pointer resets so that source 0 wins first.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r <= IDLE;
            grant_r <= {GW{1'b0}};
            last_r  <= GW'(C_NUM_SRC - 1);
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            grant_r <= grant_next_s;
            last_r  <= last_next_s;
            busy_r  <= busy_next_s;
        end
    end

    assign GRANT = grant_r;
    assign BUSY  = busy_r;

`ifdef NET2AXIS_ARB_STATS_EN
    for (genvar i = 0; i < C_NUM_SRC; i++) begin : g_stats
        logic [COUNTER_WIDTH-1:0] cnt_r;

        // Completed-packet counter for source i, saturating.
        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                cnt_r <= {COUNTER_WIDTH{1'b0}};
            end else if (beat_last_s && (grant_r == GW'(i))) begin
                cnt_r <= sat_inc(cnt_r);
            end else begin
                cnt_r <= cnt_r;
            end
        end

        assign PKT_CNT[16*i +: 16] = cnt_r;
    end
`else
    assign PKT_CNT = {(C_NUM_SRC*16){1'b0}};
`endif

endmodule

// File: tb/tb_net2axis_stream_arbiter.sv
// Self-checking bench for net2axis_stream_arbiter: directed scenarios plus a
// randomized run checked against a round-robin packet model.
module tb_net2axis_stream_arbiter;

    localparam int W  = 32;
    localparam int N  = 2;
    localparam int KW = W / 8;
    localparam int GW = 1;
    localparam int D  = 64;

    logic            ACLK = 1'b0;
    logic            ARESETN;
    logic            ENABLE;
    logic [N-1:0]    S_TVALID, S_TLAST, S_TREADY;
    logic [N*W-1:0]  S_TDATA;
    logic [N*KW-1:0] S_TKEEP;
    logic            M_TVALID, M_TLAST, M_TREADY;
    logic [W-1:0]    M_TDATA;
    logic [KW-1:0]   M_TKEEP;
    logic [GW-1:0]   GRANT;
    logic            BUSY;
    logic [N*16-1:0] PKT_CNT;

    net2axis_stream_arbiter #(.C_TDATA_WIDTH(W), .C_NUM_SRC(N)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE),
        .S_AXIS_TVALID(S_TVALID), .S_AXIS_TDATA(S_TDATA), .S_AXIS_TKEEP(S_TKEEP),
        .S_AXIS_TLAST(S_TLAST), .S_AXIS_TREADY(S_TREADY),
        .M_AXIS_TVALID(M_TVALID), .M_AXIS_TDATA(M_TDATA), .M_AXIS_TKEEP(M_TKEEP),
        .M_AXIS_TLAST(M_TLAST), .M_AXIS_TREADY(M_TREADY),
        .GRANT(GRANT), .BUSY(BUSY), .PKT_CNT(PKT_CNT)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;

    // Source-side packet memories and AXI source state
    logic [W-1:0]  mem_d [N][D];
    logic [KW-1:0] mem_k [N][D];
    logic          mem_l [N][D];
    int            rd_p [N];
    int            wr_p [N];
    bit            src_vld [N];
    int            vld_pct;

    // Values sampled in the cycle just completed
    bit [N-1:0] smp_hs, smp_vld, smp_lastbeat;
    bit         smp_en, smp_rdy;

    // Behavioural model
    bit m_busy;
    int m_grant, m_last;
    int m_cnt [N];

    function automatic int rr(input bit [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit drained();
        for (int i = 0; i < N; i++) if (rd_p[i] != wr_p[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_beat(input int s, input logic [W-1:0] d, input bit l);
        mem_d[s][wr_p[s]] = d;
        mem_k[s][wr_p[s]] = KW'($urandom_range(1, (1 << KW) - 1));
        mem_l[s][wr_p[s]] = l;
        wr_p[s]++;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0; ENABLE = 1'b1; M_TREADY = 1'b1; vld_pct = 100;
        S_TVALID = '0; S_TDATA = '0; S_TKEEP = '0; S_TLAST = '0;
        for (int i = 0; i < N; i++) begin rd_p[i] = 0; wr_p[i] = 0; src_vld[i] = 1'b0; end
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
    endtask

    // Present source beats, then wait for the sampling point (falling edge)
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!src_vld[i] && rd_p[i] < wr_p[i] && $urandom_range(0, 99) < vld_pct) src_vld[i] = 1'b1;
            S_TVALID[i]         = src_vld[i];
            S_TDATA[i*W +: W]   = src_vld[i] ? mem_d[i][rd_p[i]] : '0;
            S_TKEEP[i*KW +: KW] = src_vld[i] ? mem_k[i][rd_p[i]] : '0;
            S_TLAST[i]          = src_vld[i] ? mem_l[i][rd_p[i]] : 1'b0;
        end
        @(negedge ACLK);
    endtask

    task automatic advance();
        for (int i = 0; i < N; i++) begin
            smp_hs[i]       = S_TVALID[i] && S_TREADY[i];
            smp_vld[i]      = src_vld[i];
            smp_lastbeat[i] = src_vld[i] && mem_l[i][rd_p[i]];
        end
        smp_en  = ENABLE;
        smp_rdy = M_TREADY;
        @(posedge ACLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (smp_hs[i]) begin rd_p[i]++; src_vld[i] = 1'b0; end
        end
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (smp_en && smp_vld != '0) begin m_grant = rr(smp_vld, m_last); m_busy = 1'b1; end
        end else if (smp_vld[m_grant] && smp_rdy && smp_lastbeat[m_grant]) begin
            m_busy = 1'b0; m_last = m_grant;
            if (m_cnt[m_grant] < 65535) m_cnt[m_grant]++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        drive();
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", BUSY); end
        checks++; if (GRANT !== '0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", GRANT); end
        checks++; if (M_TVALID !== 1'b0 || M_TLAST !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%0b/%0b exp=0/0", M_TVALID, M_TLAST); end
        checks++; if (M_TDATA !== '0 || M_TKEEP !== '0) begin failures++; $display("FAIL reset_mdata got=%0h/%0h exp=0/0", M_TDATA, M_TKEEP); end
        checks++; if (S_TREADY !== '0) begin failures++; $display("FAIL reset_sready got=%0b exp=0", S_TREADY); end
        checks++; if (PKT_CNT !== '0) begin failures++; $display("FAIL reset_pktcnt got=%0h exp=0", PKT_CNT); end
        advance();
    endtask

    task automatic test_single_src();
        logic [W-1:0] exp_d [3];
        int busy_cnt = 0;
        exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
        do_reset();
        add_beat(0, 32'h11, 1'b0); add_beat(0, 32'h22, 1'b0); add_beat(0, 32'h33, 1'b1);
        drive();
        checks++; if (M_TVALID !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL single_latency got=%0b/%0b exp=0/0", M_TVALID, BUSY); end
        advance();
        for (int t = 1; t <= 5; t++) begin
            drive();
            if (BUSY) busy_cnt++;
            if (t <= 3) begin
                checks++;
                if (M_TVALID !== 1'b1 || M_TDATA !== exp_d[t-1] || M_TLAST !== (t == 3) || S_TREADY !== 2'b01)
                    begin failures++; $display("FAIL single_beat%0d got=%0b/%0h/%0b/%0b exp=1/%0h/%0b/01", t, M_TVALID, M_TDATA, M_TLAST, S_TREADY, exp_d[t-1], t == 3); end
            end
            advance();
        end
        drive();
        checks++; if (busy_cnt != 3) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=3", busy_cnt); end
        checks++; if (BUSY !== 1'b0 || GRANT !== 1'b0) begin failures++; $display("FAIL single_end got=%0b/%0d exp=0/0", BUSY, GRANT); end
        advance();
    endtask

    task automatic test_alternate();
        int ng = 0, e = 0;
        bit prev_busy = 1'b0, done = 1'b0;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++)
                for (int b = 0; b < 2; b++) add_beat(s, W'(32'h100 * s + 32'h10 * p + b), b == 1);
        for (int t = 0; t < 40 && !done; t++) begin
            drive();
            if (BUSY && !prev_busy) begin
                e = ng % 2; ng++;
                checks++; if (GRANT !== GW'(e)) begin failures++; $display("FAIL alt_grant pkt%0d got=%0d exp=%0d", ng, GRANT, e); end
            end
            if (BUSY) begin
                checks++;
                if (M_TVALID !== 1'b1 || M_TDATA !== mem_d[e][rd_p[e]] || GRANT !== GW'(e))
                    begin failures++; $display("FAIL alt_beat got=%0b/%0h/g%0d exp=1/%0h/g%0d", M_TVALID, M_TDATA, GRANT, mem_d[e][rd_p[e]], e); end
            end
            prev_busy = BUSY;
            if (drained() && !BUSY) done = 1'b1;
            advance();
        end
        checks++; if (!done || ng != 4) begin failures++; $display("FAIL alt_packets got=%0d done=%0b exp=4", ng, done); end
`ifdef NET2AXIS_ARB_STATS_EN
        checks++; if (PKT_CNT !== {16'd2, 16'd2}) begin failures++; $display("FAIL alt_pktcnt got=%0h exp=00020002", PKT_CNT); end
`else
        checks++; if (PKT_CNT !== '0) begin failures++; $display("FAIL alt_pktcnt got=%0h exp=0", PKT_CNT); end
`endif
    endtask

    task automatic test_backpressure();
        int busy_cnt = 0, beat = 0;
        do_reset();
        for (int b = 0; b < 4; b++) add_beat(0, W'(32'hA0 + b), b == 3);
        for (int t = 0; t < 12; t++) begin
            M_TREADY = (t >= 1) && (t % 2 == 0);
            drive();
            if (BUSY) begin
                busy_cnt++;
                checks++;
                if (M_TVALID !== 1'b1 || M_TDATA !== W'(32'hA0 + beat) || S_TREADY !== {1'b0, M_TREADY})
                    begin failures++; $display("FAIL bp_cycle%0d got=%0b/%0h/%0b exp=1/%0h/0%0b", t, M_TVALID, M_TDATA, S_TREADY, 32'hA0 + beat, M_TREADY); end
                if (M_TREADY) beat++;
            end
            advance();
        end
        M_TREADY = 1'b1;
        checks++; if (busy_cnt != 8 || beat != 4) begin failures++; $display("FAIL bp_length got=%0d/%0d exp=8/4", busy_cnt, beat); end
    endtask

    task automatic test_enable();
        do_reset();
        ENABLE = 1'b0;
        add_beat(1, 32'hB0, 1'b0); add_beat(1, 32'hB1, 1'b1);
        for (int t = 0; t < 3; t++) begin
            drive();
            checks++; if (BUSY !== 1'b0 || S_TREADY !== '0 || M_TVALID !== 1'b0) begin failures++; $display("FAIL en_off got=%0b/%0b/%0b exp=0/0/0", BUSY, S_TREADY, M_TVALID); end
            advance();
        end
        ENABLE = 1'b1;
        drive();
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL en_rise got=%0b exp=0", BUSY); end
        advance();
        drive();
        checks++; if (BUSY !== 1'b1 || GRANT !== 1'b1 || M_TDATA !== 32'hB0) begin failures++; $display("FAIL en_grant got=%0b/%0d/%0h exp=1/1/b0", BUSY, GRANT, M_TDATA); end
        advance();
        ENABLE = 1'b0;
        add_beat(0, 32'hC0, 1'b1);
        drive();
        checks++; if (BUSY !== 1'b1 || GRANT !== 1'b1 || M_TDATA !== 32'hB1 || M_TLAST !== 1'b1) begin failures++; $display("FAIL en_drop got=%0b/%0d/%0h/%0b exp=1/1/b1/1", BUSY, GRANT, M_TDATA, M_TLAST); end
        advance();
        for (int t = 0; t < 3; t++) begin
            drive();
            checks++; if (BUSY !== 1'b0 || S_TREADY !== '0 || rd_p[1] != 2) begin failures++; $display("FAIL en_hold got=%0b/%0b/%0d exp=0/0/2", BUSY, S_TREADY, rd_p[1]); end
            advance();
        end
        ENABLE = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_beat(0, 32'hD0, 1'b1);
        repeat (3) begin drive(); advance(); end
        for (int b = 0; b < 4; b++) add_beat(1, W'(32'hE0 + b), b == 3);
        repeat (2) begin drive(); advance(); end
        drive();
        checks++; if (BUSY !== 1'b1 || GRANT !== 1'b1 || M_TDATA !== 32'hE1) begin failures++; $display("FAIL rstmid_pre got=%0b/%0d/%0h exp=1/1/e1", BUSY, GRANT, M_TDATA); end
        ARESETN = 1'b0;
        #1;
        checks++; if (M_TVALID !== 1'b0 || BUSY !== 1'b0 || S_TREADY !== '0) begin failures++; $display("FAIL rstmid_async got=%0b/%0b/%0b exp=0/0/0", M_TVALID, BUSY, S_TREADY); end
        for (int i = 0; i < N; i++) begin rd_p[i] = 0; wr_p[i] = 0; src_vld[i] = 1'b0; end
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        add_beat(0, 32'hF0, 1'b1); add_beat(1, 32'hF1, 1'b1);
        drive(); advance();
        drive();
        checks++; if (BUSY !== 1'b1 || GRANT !== 1'b0 || M_TDATA !== 32'hF0) begin failures++; $display("FAIL rstmid_regrant got=%0b/%0d/%0h exp=1/0/f0", BUSY, GRANT, M_TDATA); end
        advance();
    endtask

    task automatic test_single_beat();
        logic [4:0] exp_busy = 5'b01010;
        int g = 0;
        do_reset();
        add_beat(0, 32'h51, 1'b1); add_beat(1, 32'h52, 1'b1);
        for (int t = 0; t < 5; t++) begin
            drive();
            checks++; if (BUSY !== exp_busy[t]) begin failures++; $display("FAIL sbeat_busy t%0d got=%0b exp=%0b", t, BUSY, exp_busy[t]); end
            if (exp_busy[t]) begin
                checks++;
                if (GRANT !== GW'(g) || M_TLAST !== 1'b1 || M_TDATA !== W'(32'h51 + g))
                    begin failures++; $display("FAIL sbeat_pkt t%0d got=%0d/%0b/%0h exp=%0d/1/%0h", t, GRANT, M_TLAST, M_TDATA, g, 32'h51 + g); end
                g++;
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        bit exp_v, done = 1'b0;
        int errs = 0, total = 0;
        do_reset();
        m_busy = 1'b0; m_grant = 0; m_last = N - 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        for (int s = 0; s < N; s++)
            for (int p = 0; p < 6; p++) begin
                int len = $urandom_range(1, 5);
                for (int b = 0; b < len; b++) add_beat(s, W'($urandom), b == len - 1);
            end
        vld_pct = 60;
        for (int t = 0; t < 800 && !done; t++) begin
            M_TREADY = ($urandom_range(0, 99) < 75);
            ENABLE   = ($urandom_range(0, 99) < 90);
            drive();
            exp_v = m_busy && src_vld[m_grant];
            er = '0;
            if (m_busy) er[m_grant] = M_TREADY;
            checks++;
            if (BUSY !== m_busy || (m_busy && GRANT !== GW'(m_grant)) || M_TVALID !== exp_v || S_TREADY !== er ||
                (exp_v && (M_TDATA !== mem_d[m_grant][rd_p[m_grant]] || M_TKEEP !== mem_k[m_grant][rd_p[m_grant]] ||
                           M_TLAST !== mem_l[m_grant][rd_p[m_grant]]))) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL rand_cycle%0d got=b%0b g%0d v%0b r%0b d%0h exp=b%0b g%0d v%0b r%0b", t, BUSY, GRANT, M_TVALID, S_TREADY, M_TDATA, m_busy, m_grant, exp_v, er);
            end
            if (drained() && !m_busy) done = 1'b1;
            advance();
            model_step();
        end
        for (int i = 0; i < N; i++) total += m_cnt[i];
        checks++; if (!done || total != 6 * N) begin failures++; $display("FAIL rand_drain got=%0d done=%0b exp=%0d", total, done, 6 * N); end
`ifdef NET2AXIS_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            checks++; if (PKT_CNT[16*i +: 16] !== 16'(m_cnt[i])) begin failures++; $display("FAIL rand_pktcnt%0d got=%0d exp=%0d", i, PKT_CNT[16*i +: 16], m_cnt[i]); end
        end
`else
        checks++; if (PKT_CNT !== '0) begin failures++; $display("FAIL rand_pktcnt got=%0h exp=0", PKT_CNT); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_src();
        test_alternate();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_single_beat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
